moving_average_stream: RTL and testbench

- Streaming signed moving-average filter with a run-time selectable power-of-two window (1..2^LOG2_DEPTH samples).
- Uses a circular history buffer and a running sum: one add/subtract per sample instead of a full re-accumulation pass.
- Valid/ready handshake on both input and output, so it sits directly between the audio sample source and the visualiser bar/level logic.
- Replaces the fixed 32-tap, FSM-sequenced averager with a parametrised, single-cycle-per-sample block.

---
 rtl/moving_average_stream.sv | 119 +++++++++++
 tb/tb_moving_average_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_stream.sv
// Streaming signed moving-average filter with a run-time power-of-two window.
// A circular history buffer and a running sum give one add/subtract per sample.
// Optional build macro: MOVING_AVERAGE_STREAM_ROUNDING_EN selects round-half-up
// with saturation instead of the default floor (arithmetic shift) output.
module moving_average_stream #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LOG2_DEPTH = 5,
    parameter int unsigned SEL_W      = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic [SEL_W-1:0]  win_sel,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              primed
);

    localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int unsigned FILL_W = LOG2_DEPTH + 1;

    logic [SEL_W-1:0]         k;
    logic [LOG2_DEPTH-1:0]    wr_ptr;
    logic [FILL_W-1:0]        fill;
    logic signed [SUM_W-1:0]  sum;
    logic [DATA_W-1:0]        hist_mem [DEPTH];

    logic                     in_fire;
    logic                     out_fire;
    logic [FILL_W-1:0]        window;
    logic [LOG2_DEPTH-1:0]    rd_idx;
    logic [DATA_W-1:0]        old;
    logic signed [SUM_W-1:0]  sum_next;
    logic [FILL_W-1:0]        fill_next;
    logic [SEL_W-1:0]         k_clamped;
    logic [DATA_W-1:0]        avg;

`ifdef MOVING_AVERAGE_STREAM_ROUNDING_EN
    localparam int unsigned RND_W = SUM_W + 1;
    localparam logic signed [RND_W-1:0] SAT_MAX =
        $signed({{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [RND_W-1:0] SAT_MIN =
        $signed({{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    logic signed [RND_W-1:0]  rnd_bias;
    logic signed [RND_W-1:0]  rnd_sum;
    logic signed [RND_W-1:0]  rnd_shift;
`endif

    assign in_ready = !clear && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Next running sum, fill level and averaged output for the offered sample
    always_comb begin
        window    = FILL_W'(1) << k;
        rd_idx    = wr_ptr - window[LOG2_DEPTH-1:0];
        old       = (fill == window) ? hist_mem[rd_idx] : '0;
        sum_next  = sum + SUM_W'($signed(in_data)) - SUM_W'($signed(old));
        fill_next = (fill == window) ? fill : fill + FILL_W'(1);
        k_clamped = (win_sel > SEL_W'(LOG2_DEPTH)) ? SEL_W'(LOG2_DEPTH) : win_sel;
`ifdef MOVING_AVERAGE_STREAM_ROUNDING_EN
        rnd_bias  = (k == '0) ? '0 : (RND_W'(1) << (k - SEL_W'(1)));
        rnd_sum   = RND_W'(sum_next) + rnd_bias;
        rnd_shift = rnd_sum >>> k;
        if (rnd_shift > SAT_MAX) begin
            avg = SAT_MAX[DATA_W-1:0];
        end else if (rnd_shift < SAT_MIN) begin
            avg = SAT_MIN[DATA_W-1:0];
        end else begin
            avg = rnd_shift[DATA_W-1:0];
        end
`else
        // The average always fits DATA_W, so floor(sum/2^k) is just a bit slice
        avg = sum_next[k +: DATA_W];
`endif
    end

    // History buffer write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            hist_mem[wr_ptr] <= in_data;
        end
    end

    // Filter state and registered output handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k         <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (clear) begin
            k         <= k_clamped;
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else if (in_fire) begin
            wr_ptr    <= wr_ptr + LOG2_DEPTH'(1);
            fill      <= fill_next;
            sum       <= sum_next;
            out_valid <= 1'b1;
            out_data  <= avg;
            primed    <= (fill_next == window);
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_average_stream.sv
// Scoreboard bench for moving_average_stream with a window-of-history reference model.
module tb_moving_average_stream;

    localparam int DATA_W     = 16;
    localparam int LOG2_DEPTH = 5;
    localparam int SEL_W      = 3;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b1;
    logic                     clear = 1'b0;
    logic [SEL_W-1:0]         win_sel = '0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_ready = 1'b0;
    logic                     primed;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int seen[$];
    int hist[$];
    int m_k   = 0;
    int m_cnt = 0;
    int last_out = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    moving_average_stream #(
        .DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .win_sel(win_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .primed(primed)
    );

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: mean of the last 2^k accepted samples, missing history counted as zero
    function automatic int model_avg();
        int     w = 1 << m_k;
        longint s = 0;
        longint q;
        for (int i = 0; i < w && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
`ifdef MOVING_AVERAGE_STREAM_ROUNDING_EN
        if (m_k > 0) s += w / 2;
`endif
        q = s / w;
        if ((s % w) != 0 && s < 0) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic model_accept(int d);
        hist.push_back(d);
        if (hist.size() > (1 << LOG2_DEPTH)) void'(hist.pop_front());
        if (m_cnt < (1 << m_k)) m_cnt++;
        exp_q.push_back(model_avg());
    endtask

    task automatic model_reset(int ws);
        m_k = (ws > LOG2_DEPTH) ? LOG2_DEPTH : ws;
        hist.delete();
        exp_q.delete();
        m_cnt = 0;
    endtask

    // Monitor: every consumed output must match the oldest expected value
    always @(negedge clk) begin
        if (resetn && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d expected none", out_data);
            end else begin
                check("out_data", int'(out_data), exp_q.pop_front());
            end
            last_out = int'(out_data);
            seen.push_back(int'(out_data));
        end
    end

    // Random backpressure when enabled
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(int d);
        int waited = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        forever begin
            @(negedge clk);
            if (in_ready || waited > 200) break;
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for data %0d", d);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("primed", int'(primed), int'(m_cnt == (1 << m_k)));
    endtask

    task automatic do_clear(int ws);
        @(posedge clk);
        #1;
        clear   = 1'b1;
        win_sel = SEL_W'(ws);
        @(posedge clk);
        model_reset(ws);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clear_out_valid", int'(out_valid), 0);
        check("clear_primed", int'(primed), 0);
    endtask

    task automatic check_seen(string name, int exp[$]);
        check({name, "_count"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++) check(name, seen[i], exp[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        int d;

        // Reset state
        #2 resetn = 1'b0;
        #20;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        model_reset(0);
        out_ready = 1'b1;

        // Window 4
        do_clear(2);
        seen.delete();
        send(4); send(8); send(12); send(16); send(0);
        repeat (3) @(negedge clk);
        e = '{1, 3, 6, 10, 9};
        check_seen("win4", e);

        // Window 2, negative samples
        do_clear(1);
        seen.delete();
        send(-3); send(-5);
        repeat (3) @(negedge clk);
`ifdef MOVING_AVERAGE_STREAM_ROUNDING_EN
        e = '{-1, -4};
`else
        e = '{-2, -4};
`endif
        check_seen("win2_neg", e);

        // Clamped full window at both extremes
        do_clear(7);
        for (int i = 0; i < 32; i++) send(32767);
        repeat (2) @(negedge clk);
        check("full_pos_last", last_out, 32767);
        check("full_pos_primed", int'(primed), 1);
        for (int i = 0; i < 32; i++) send(-32768);
        repeat (2) @(negedge clk);
        check("full_neg_last", last_out, -32768);

        // Backpressure holds output and blocks input
        do_clear(0);
        seen.delete();
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(5);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = DATA_W'(9);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 5);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        model_accept(9);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        e = '{5, 9};
        check_seen("bp", e);

        // Clear beats a same-cycle input and a pending output
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(20);
        @(posedge clk);
        #1;
        clear    = 1'b1;
        win_sel  = SEL_W'(3);
        in_valid = 1'b1;
        in_data  = DATA_W'(100);
        @(negedge clk);
        check("clr_in_ready", int'(in_ready), 0);
        check("clr_pending_valid", int'(out_valid), 1);
        @(posedge clk);
        model_reset(3);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_drop_valid", int'(out_valid), 0);
        check("clr_drop_primed", int'(primed), 0);
        seen.delete();
        out_ready = 1'b1;
        send(8);
        repeat (3) @(negedge clk);
        e = '{1};
        check_seen("clr_win8", e);

        // Asynchronous reset mid-stream
        do_clear(2);
        for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 2000)) - 1000);
        check("pre_rst_primed", int'(primed), 1);
        @(posedge clk);
        #3 resetn = 1'b0;
        model_reset(0);
        #1;
        check("async_out_valid", int'(out_valid), 0);
        check("async_out_data", int'(out_data), 0);
        check("async_primed", int'(primed), 0);
        @(posedge clk);
        #3 resetn = 1'b1;
        seen.delete();
        send(7);
        repeat (3) @(negedge clk);
        e = '{7};
        check_seen("post_rst", e);

        // Randomized windows, data and backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_clear(int'($urandom_range(0, 7)));
            for (int i = 0; i < 40; i++) begin
                d = int'($urandom_range(0, 65535)) - 32768;
                send(d);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
